// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: default geometry and requester ids.
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DFLT = 3;
    localparam int unsigned DATA_W_DFLT = 72;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return (id == REQ1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arb_2x72_rr_arb2.sv
// Two-way round-robin pick: with both valid, the requester that did not win last time wins.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = id_to_onehot(~last_grant);
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arb_2x72.sv
// Round-robin arbiter sharing one synchronous single-port RAM between two requesters,
// with zero-latency grants and one-cycle read responses routed back to the owner.
module ram_arb_2x72
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DFLT,
    parameter int unsigned DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              last_grant_q;
    logic              rd_pend_q;
    logic              rd_owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic [1:0]        grant_raw;
    logic [1:0]        grant;
    logic              any_grant;
    logic              sel_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant_raw)
    );

    // Grants are suppressed under reset so nothing reaches the RAM or the response path.
    always_comb begin
        grant     = rst ? 2'b00 : grant_raw;
        any_grant = |grant;
        sel_id    = grant[1] ? REQ1 : REQ0;
        sel_we    = (sel_id == REQ1) ? req1_we    : req0_we;
        sel_addr  = (sel_id == REQ1) ? req1_addr  : req0_addr;
        sel_wdata = (sel_id == REQ1) ? req1_wdata : req0_wdata;
    end

    always_comb begin
        req0_ready  = grant[0];
        req1_ready  = grant[1];
        ram_wr      = any_grant ? ~sel_we   : 1'b1;
        ram_address = any_grant ? sel_addr  : addr_q;
        ram_wdata   = any_grant ? sel_wdata : wdata_q;
    end

    // RAM data is valid the cycle after the read address, so the response is combinational
    // from the pending-read registers; the rdata registers only hold the last returned word.
    always_comb begin
        rsp0_valid = rd_pend_q && (rd_owner_q == REQ0);
        rsp1_valid = rd_pend_q && (rd_owner_q == REQ1);
        rsp0_rdata = rsp0_valid ? ram_rdata : rdata0_q;
        rsp1_rdata = rsp1_valid ? ram_rdata : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= REQ1;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= REQ0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            rd_pend_q <= any_grant && !sel_we;
            if (any_grant) begin
                last_grant_q <= sel_id;
                rd_owner_q   <= sel_id;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
            end
            if (rsp0_valid) begin
                rdata0_q <= ram_rdata;
            end
            if (rsp1_valid) begin
                rdata1_q <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_arb_2x72.sv
// Directed bench for ram_arb_2x72 with a behavioural synchronous RAM attached.
module tb_ram_arb_2x72;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_we;
    logic [2:0]  req0_addr;
    logic [71:0] req0_wdata;
    logic        rsp0_valid;
    logic [71:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [2:0]  req1_addr;
    logic [71:0] req1_wdata;
    logic        rsp1_valid;
    logic [71:0] rsp1_rdata;
    logic        ram_wr;
    logic [2:0]  ram_address;
    logic [71:0] ram_wdata;
    logic [71:0] ram_rdata;

    logic [71:0] mem [8];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arb_2x72 dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_we     (req0_we),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .rsp0_valid  (rsp0_valid),
        .rsp0_rdata  (rsp0_rdata),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_we     (req1_we),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .rsp1_valid  (rsp1_valid),
        .rsp1_rdata  (rsp1_rdata),
        .ram_wr      (ram_wr),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Synchronous RAM: write on ram_wr == 0, registered read, preloaded with 100 + index.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 72'(100 + i);
            ram_rdata <= '0;
        end else begin
            if (!ram_wr) mem[ram_address] <= ram_wdata;
            ram_rdata <= mem[ram_address];
        end
    end

    typedef struct {
        logic        v0, we0;
        logic [2:0]  a0;
        logic [71:0] d0;
        logic        v1, we1;
        logic [2:0]  a1;
        logic [71:0] d1;
        logic        r0, r1, wr;
        logic [2:0]  addr;
        logic [71:0] wd;
        logic        rv0, rv1;
        logic [71:0] rd0, rd1;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(
        input logic v0, input logic we0, input logic [2:0] a0, input logic [71:0] d0,
        input logic v1, input logic we1, input logic [2:0] a1, input logic [71:0] d1,
        input logic r0, input logic r1, input logic wr, input logic [2:0] addr,
        input logic [71:0] wd, input logic rv0, input logic rv1,
        input logic [71:0] rd0, input logic [71:0] rd1);
        vec_t v;
        v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.wr = wr; v.addr = addr; v.wd = wd;
        v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic we0, input logic [2:0] a0,
                         input logic [71:0] d0, input logic v1, input logic we1,
                         input logic [2:0] a1, input logic [71:0] d1);
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, ".req0_ready"}, 72'(req0_ready), 72'(e.r0));
        check({tag, ".req1_ready"}, 72'(req1_ready), 72'(e.r1));
        check({tag, ".ram_wr"}, 72'(ram_wr), 72'(e.wr));
        check({tag, ".ram_address"}, 72'(ram_address), 72'(e.addr));
        check({tag, ".ram_wdata"}, ram_wdata, e.wd);
        check({tag, ".rsp0_valid"}, 72'(rsp0_valid), 72'(e.rv0));
        check({tag, ".rsp1_valid"}, 72'(rsp1_valid), 72'(e.rv1));
        check({tag, ".rsp0_rdata"}, rsp0_rdata, e.rd0);
        check({tag, ".rsp1_rdata"}, rsp1_rdata, e.rd1);
    endtask

    initial begin
        //           v0 w0 a0 d0   v1 w1 a1 d1   r0 r1 wr addr wd  rv0 rv1 rd0  rd1
        vecs[0]  = mk(1, 1, 3, 40, 0, 0, 0, 0,   1, 0, 0, 3, 40,  0, 0, 0,   0);
        vecs[1]  = mk(0, 0, 0, 0,  1, 0, 3, 0,   0, 1, 1, 3, 0,   0, 0, 0,   0);
        vecs[2]  = mk(1, 0, 0, 0,  1, 0, 1, 0,   1, 0, 1, 0, 0,   0, 1, 0,   40);
        vecs[3]  = mk(1, 0, 2, 0,  1, 0, 1, 0,   0, 1, 1, 1, 0,   1, 0, 100, 40);
        vecs[4]  = mk(1, 0, 2, 0,  1, 0, 3, 0,   1, 0, 1, 2, 0,   0, 1, 100, 101);
        vecs[5]  = mk(1, 0, 6, 0,  1, 0, 3, 0,   0, 1, 1, 3, 0,   1, 0, 102, 101);
        vecs[6]  = mk(1, 0, 6, 0,  0, 0, 0, 0,   1, 0, 1, 6, 0,   0, 1, 102, 40);
        vecs[7]  = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 1, 6, 0,   1, 0, 106, 40);
        vecs[8]  = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 1, 6, 0,   0, 0, 106, 40);
        vecs[9]  = mk(1, 1, 4, 11, 1, 1, 5, 22,  0, 1, 0, 5, 22,  0, 0, 106, 40);
        vecs[10] = mk(1, 1, 4, 11, 0, 0, 0, 0,   1, 0, 0, 4, 11,  0, 0, 106, 40);
        vecs[11] = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 1, 4, 11,  0, 0, 106, 40);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_outputs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
                  vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
            #2;
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset coinciding with a read grant: the read must never produce a response.
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_outputs("rst_rd0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #2;
        check_outputs("rst_rd1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        // After reset requester 0 wins a tie.
        @(negedge clk);
        drive(1, 0, 1, 0, 1, 0, 2, 0);
        #2;
        check("post_rst_tie.req0_ready", 72'(req0_ready), 72'd1);
        check("post_rst_tie.req1_ready", 72'(req1_ready), 72'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 2, 0);
        #2;
        check("post_rst_tie.rsp0_rdata", rsp0_rdata, 72'd101);
        check("post_rst_tie.req1_ready2", 72'(req1_ready), 72'd1);

        // Write from requester 1 then read of the same address by requester 0.
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 1, 7, 20);
        #2;
        check("wr7.req1_ready", 72'(req1_ready), 72'd1);
        check("wr7.rsp1_rdata", rsp1_rdata, 72'd102);
        check("wr7.ram_wr", 72'(ram_wr), 72'd0);
        @(negedge clk);
        drive(1, 0, 7, 0, 0, 0, 0, 0);
        #2;
        check("rd7.req0_ready", 72'(req0_ready), 72'd1);
        check("rd7.rsp1_valid", 72'(rsp1_valid), 72'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("rd7.rsp0_valid", 72'(rsp0_valid), 72'd1);
        check("rd7.rsp0_rdata", rsp0_rdata, 72'd20);
        check("rd7.rsp1_valid2", 72'(rsp1_valid), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arb_2x72.md
RAM_ARB_2X72 -- requirements
Module: ram_arb_2x72

Interface
REQ-001 SHALL take parameter ADDR_W, default 3: RAM address width (8 entries).
REQ-002 SHALL take parameter DATA_W, default 72: RAM word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an access pending.
REQ-006 req0_ready  output  1  requester 0 access accepted this cycle.
REQ-007 req0_we  input  1  1 = write, 0 = read.
REQ-008 req0_addr  input  ADDR_W  requester 0 address.
REQ-009 req0_wdata  input  DATA_W  requester 0 write data.
REQ-010 rsp0_valid  output  1  requester 0 read data valid, one-cycle pulse.
REQ-011 rsp0_rdata  output  DATA_W  requester 0 read data.
REQ-012 req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same directions, widths and meanings as REQ-005..REQ-011, for requester 1.
REQ-013 ram_wr  output  1  RAM write strobe, active-low (0 = write, 1 = read).
REQ-014 ram_address  output  ADDR_W  RAM address.
REQ-015 ram_wdata  output  DATA_W  RAM write data.
REQ-016 ram_rdata  input  DATA_W  RAM read data, valid one cycle after the read address is presented.

Function
REQ-017 SHALL grant at most one requester per cycle; a grant is req*_valid && req*_ready in the same cycle.
REQ-018 SHALL assert req*_ready combinationally, with zero-cycle grant latency, for the winner only; the loser's ready stays 0.
REQ-019 SHALL arbitrate round-robin via a 1-bit last_grant register.
  - Both valid: grant the requester not equal to last_grant.
  - One valid: grant it.
  - Update last_grant on every grant.
REQ-020 SHALL drive the granted requester's addr and wdata onto ram_address and ram_wdata, and drive ram_wr = ~we, in the grant cycle.
REQ-021 SHALL, with no grant, hold ram_wr = 1 and ram_address/ram_wdata at their previous values (no spurious write).
REQ-022 SHALL, on a granted read, record the owner in rd_pend and rd_owner registers, then assert rsp<owner>_valid with rsp<owner>_rdata = ram_rdata in the next cycle.
REQ-023 SHALL allow back-to-back grants every cycle; a read response and a new grant may coincide.
REQ-024 SHALL return new data for a read to address A granted the cycle after a write to A (RAM write-then-read ordering).
REQ-025 SHALL assert rsp*_valid only for reads, never for writes; rsp*_rdata holds its last value when valid is 0.
REQ-026 SHALL ensure a requester holding valid is granted within 2 cycles (no starvation).
REQ-027 SHALL require requesters to hold valid/we/addr/wdata stable until ready; the block does not register requests.

Reset
REQ-028 SHALL, while rst = 1, force the following on the next edge:
  - req0_ready = req1_ready = 0, rsp0_valid = rsp1_valid = 0.
  - ram_wr = 1, ram_address = 0, ram_wdata = 0.
  - last_grant = 1 (requester 0 wins first), rd_pend = 0.
  - rsp*_rdata = 0.
REQ-029 SHALL drop a read granted in the cycle rst asserts; no response is issued after reset.

Structure
REQ-030 SHALL place ADDR_W/DATA_W defaults and the requester-id constants (REQ0 = 0, REQ1 = 1) in the shared package ram_arb_pkg.
REQ-031 SHALL implement the round-robin pick as a sub-module rr_arb2 (inputs: valid[1:0], last_grant; output: one-hot grant[1:0]).

Verification
REQ-032 Reset, then req0 writes addr 3 = 72'd40 -> ram_wr = 0, ram_address = 3, ram_wdata = 40 in the same cycle; no rsp pulse.
REQ-033 req1 reads addr 3 the next cycle -> rsp1_valid = 1 one cycle later, rsp1_rdata = 72'd40; rsp0_valid stays 0.
REQ-034 Both valid every cycle for 4 cycles, reads of addrs 0..3 -> grants alternate 0,1,0,1 starting with requester 0; each response goes to the correct owner.
REQ-035 Idle cycle after traffic -> ram_wr = 1 and address unchanged.
REQ-036 rst asserted in the cycle req0's read of addr 5 is granted -> no rsp0_valid afterward; all outputs hold reset values.
REQ-037 Write addr 7 = 72'd20 (req1), then read addr 7 (req0) the next cycle -> rsp0_rdata = 72'd20.
